// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the pipelined RISC-V core.
// Owns the fetch PC, fetches 32-bit words over a req/ack handshake,
// buffers them in a 2-entry prefetch FIFO and presents one registered
// instruction per cycle to decode (a canonical NOP when nothing is valid).
// A redirect flushes buffered words and reloads the fetch PC.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky misaligned-target
// fault that halts fetching). Without it fetch_fault is tied low and
// redirect targets are forced to word alignment.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_fault
);

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0] fetch_pc_r;
  logic [1:0]  count_r;
  logic [31:0] fifo_pc_r   [0:1];
  logic [31:0] fifo_word_r [0:1];
  logic [31:0] target_pc_s;
  logic        fault_s;
  logic        xfer_s;
  logic        load_s;
  logic        pop_s;
  logic        bypass_s;
  logic        push_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_r;

  // Sticky fault on a misaligned redirect target; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_r <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end

  assign fault_s     = fault_r;
  assign target_pc_s = redirect_pc;
`else
  assign fault_s     = 1'b0;
  // Low address bits are dropped so the fetch PC stays word aligned.
  assign target_pc_s = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign fetch_fault = fault_s;
  assign imem_addr   = fetch_pc_r;
  // No request while in reset, full, redirecting or faulted.
  assign imem_req    = !rst && (count_r < 2'd2) && !redirect && !fault_s;

  // Handshake and FIFO control decode for the current cycle.
  always_comb begin
    xfer_s   = imem_req && imem_ack;
    load_s   = !stall;
    pop_s    = load_s && (count_r != 2'd0);
    bypass_s = xfer_s && load_s && (count_r == 2'd0);
    push_s   = xfer_s && !bypass_s;
  end

  // Fetch PC: redirect target, else advance by one word per transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_r <= target_pc_s;
    end else if (xfer_s) begin
      fetch_pc_r <= fetch_pc_r + 32'd4;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // Prefetch FIFO kept as a shift structure: entry 0 is always the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r        <= 2'd0;
      fifo_pc_r[0]   <= 32'd0;
      fifo_pc_r[1]   <= 32'd0;
      fifo_word_r[0] <= 32'd0;
      fifo_word_r[1] <= 32'd0;
    end else if (redirect) begin
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          fifo_pc_r[count_r[0]]   <= fetch_pc_r;
          fifo_word_r[count_r[0]] <= imem_rdata;
          count_r                 <= count_r + 2'd1;
        end
        2'b01: begin
          fifo_pc_r[0]   <= fifo_pc_r[1];
          fifo_word_r[0] <= fifo_word_r[1];
          count_r        <= count_r - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry: the new word replaces the head.
          fifo_pc_r[0]   <= fetch_pc_r;
          fifo_word_r[0] <= imem_rdata;
          count_r        <= count_r;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Output register: FIFO head, then bypassed transfer, then NOP bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_INST;
      inst_pc     <= 32'd0;
      inst_valid  <= 1'b0;
    end else if (redirect) begin
      instruction <= NOP_INST;
      inst_pc     <= inst_pc;
      inst_valid  <= 1'b0;
    end else if (!load_s) begin
      instruction <= instruction;
      inst_pc     <= inst_pc;
      inst_valid  <= inst_valid;
    end else if (count_r != 2'd0) begin
      instruction <= fifo_word_r[0];
      inst_pc     <= fifo_pc_r[0];
      inst_valid  <= 1'b1;
    end else if (xfer_s) begin
      instruction <= imem_rdata;
      inst_pc     <= fetch_pc_r;
      inst_valid  <= 1'b1;
    end else begin
      instruction <= NOP_INST;
      inst_pc     <= inst_pc;
      inst_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit.
// Memory returns addr ^ WMASK so the word and its PC are distinguishable.
// Define FETCH_MISALIGN_TRAP_EN for both files to check the fault build.
module tb_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WMASK = 32'hA500_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_fault;

  int vec_cnt;
  int err_cnt;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instruction (instruction),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .fetch_fault (fetch_fault)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: zero-wait data derived from the address.
  assign imem_rdata = imem_addr ^ WMASK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs may then be changed safely.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check the registered output triple against an expected valid word at pc.
  task automatic expect_word(input string tag, input logic [31:0] pc);
    check({tag, ".pc"},    inst_pc, pc);
    check({tag, ".inst"},  instruction, pc ^ WMASK);
    check({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic expect_bubble(input string tag, input logic [31:0] pc);
    check({tag, ".pc"},    inst_pc, pc);
    check({tag, ".inst"},  instruction, NOP);
    check({tag, ".valid"}, {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    vec_cnt     = 0;
    err_cnt     = 0;
    rst         = 1'b1;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    stall       = 1'b0;

    // Reset state.
    tick();
    tick();
    expect_bubble("rst", 32'd0);
    check("rst.req",   {31'd0, imem_req}, 32'd0);
    check("rst.fault", {31'd0, fetch_fault}, 32'd0);

    // Release reset with no ack: request held at address 0, NOP output.
    rst = 1'b0;
    #1;
    check("rel.req",  {31'd0, imem_req}, 32'd1);
    check("rel.addr", imem_addr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("noack.req",  {31'd0, imem_req}, 32'd1);
      check("noack.addr", imem_addr, 32'd0);
      expect_bubble("noack", 32'd0);
    end

    // Streaming with ack high: one word per cycle through the bypass.
    imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_word("stream", 32'(4 * k));
      check("stream.addr", imem_addr, 32'(4 * k + 4));
    end

    // Stall four cycles: outputs frozen, exactly two words buffered.
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_word("stall", 32'd12);
      check("stall.req", {31'd0, imem_req}, (k == 0) ? 32'd1 : 32'd0);
    end
    check("stall.addr", imem_addr, 32'd24);

    // Release: buffered words drain in order, then streaming resumes.
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_word("drain", 32'(16 + 4 * k));
    end
    check("drain.addr", imem_addr, 32'd36);

    // Fill FIFO to two entries under stall, then redirect to 0x100.
    stall = 1'b1;
    tick();
    check("fill.req", {31'd0, imem_req}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    check("redir.req", {31'd0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    #1;
    expect_bubble("redir", 32'd28);
    check("redir.addr", imem_addr, 32'h0000_0100);
    check("redir.req",  {31'd0, imem_req}, 32'd1);
    tick();
    expect_word("redir.first", 32'h0000_0100);
    check("redir.next", imem_addr, 32'h0000_0104);

    // Address wrap from the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    check("wrap.req0", {31'd0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    check("wrap.valid0", {31'd0, inst_valid}, 32'd0);
    tick();
    expect_word("wrap.top", 32'hFFFF_FFFC);
    check("wrap.addr", imem_addr, 32'd0);
    tick();
    expect_word("wrap.zero", 32'd0);

    // Misaligned redirect target.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis.fault", {31'd0, fetch_fault}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("mis.req", {31'd0, imem_req}, 32'd0);
      tick();
      check("mis.valid", {31'd0, inst_valid}, 32'd0);
      check("mis.sticky", {31'd0, fetch_fault}, 32'd1);
    end
`else
    check("mis.fault", {31'd0, fetch_fault}, 32'd0);
    check("mis.addr",  imem_addr, 32'h0000_0100);
    check("mis.req",   {31'd0, imem_req}, 32'd1);
    tick();
    expect_word("mis.first", 32'h0000_0100);
`endif

    // Asynchronous reset mid-stream: everything returns to reset values.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    expect_bubble("arst", 32'd0);
    check("arst.req",   {31'd0, imem_req}, 32'd0);
    check("arst.addr",  imem_addr, 32'd0);
    check("arst.fault", {31'd0, fetch_fault}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("arst.rel.req",  {31'd0, imem_req}, 32'd1);
    check("arst.rel.addr", imem_addr, 32'd0);
    tick();
    expect_word("arst.first", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
